// File: rtl/ao486_boot_sequencer.sv
// Boot-time BIOS copier: holds the CPU in reset, copies WORDS words from boot ROM
// to SDRAM one read/write pair at a time, then releases the CPU and reports done.
module ao486_boot_sequencer #(
    parameter logic [31:0] SRC_BASE = 32'h00000000,
    parameter logic [31:0] DST_BASE = 32'h000F0000,
    parameter int unsigned WORDS    = 16384
) (
    input  logic        clk_sys,
    input  logic        rst,
    input  logic        sdram_ready,
    input  logic        reboot_req,
    output logic [31:0] rom_address,
    output logic        rom_read,
    input  logic        rom_waitrequest,
    input  logic [31:0] rom_readdata,
    input  logic        rom_readdatavalid,
    output logic [31:0] ram_address,
    output logic        ram_write,
    output logic [31:0] ram_writedata,
    input  logic        ram_waitrequest,
    output logic [1:0]  rstctl_address,
    output logic        rstctl_write,
    output logic [31:0] rstctl_writedata,
    output logic        done
);

    typedef enum logic [2:0] {IDLE, HOLD, RD_REQ, RD_WAIT, WR, RELEASE, DONE} state_t;

    localparam logic [15:0] LAST = (WORDS == 0) ? 16'd0 : 16'(WORDS - 1);

    state_t      state;
    logic [15:0] counter;

    // The reset controller has a single register; its address never changes.
    assign rstctl_address = 2'd0;

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state            <= IDLE;
            rom_read         <= 1'b0;
            ram_write        <= 1'b0;
            rstctl_write     <= 1'b0;
            rstctl_writedata <= 32'h0;
            done             <= 1'b0;
            ram_writedata    <= 32'h0;
            rom_address      <= SRC_BASE;
            ram_address      <= DST_BASE;
            counter          <= 16'd0;
        end else begin
            case (state)
                IDLE: if (sdram_ready) begin
                    state            <= HOLD;
                    rstctl_write     <= 1'b1;
                    rstctl_writedata <= 32'h1;
                end
                HOLD: begin
                    rstctl_write <= 1'b0;
                    if (WORDS != 0) begin
                        state    <= RD_REQ;
                        rom_read <= 1'b1;
                    end else begin
                        state            <= RELEASE;
                        rstctl_write     <= 1'b1;
                        rstctl_writedata <= 32'h0;
                    end
                end
                RD_REQ: if (!rom_waitrequest) begin
                    rom_read <= 1'b0;
                    // Zero-latency slaves may return data in the accept cycle.
                    if (rom_readdatavalid) begin
                        ram_writedata <= rom_readdata;
                        ram_write     <= 1'b1;
                        state         <= WR;
                    end else begin
                        state <= RD_WAIT;
                    end
                end
                RD_WAIT: if (rom_readdatavalid) begin
                    ram_writedata <= rom_readdata;
                    ram_write     <= 1'b1;
                    state         <= WR;
                end
                WR: if (!ram_waitrequest) begin
                    ram_write   <= 1'b0;
                    rom_address <= rom_address + 32'd4;
                    ram_address <= ram_address + 32'd4;
                    counter     <= counter + 16'd1;
                    if (counter == LAST) begin
                        state            <= RELEASE;
                        rstctl_write     <= 1'b1;
                        rstctl_writedata <= 32'h0;
                    end else begin
                        state    <= RD_REQ;
                        rom_read <= 1'b1;
                    end
                end
                RELEASE: begin
                    rstctl_write <= 1'b0;
                    state        <= DONE;
                    done         <= 1'b1;
                end
                DONE: if (reboot_req) begin
                    done             <= 1'b0;
                    rom_address      <= SRC_BASE;
                    ram_address      <= DST_BASE;
                    counter          <= 16'd0;
                    state            <= HOLD;
                    rstctl_write     <= 1'b1;
                    rstctl_writedata <= 32'h1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ao486_boot_sequencer.sv
// Scoreboard bench: stimulus pushes expected bus events, a negedge monitor pops and compares.
module tb_ao486_boot_sequencer;

    localparam logic [31:0] SRC = 32'h00000000;
    localparam logic [31:0] DST = 32'h000F0000;

    typedef struct packed {
        logic [1:0]  kind;   // 0 reset-ctl write, 1 rom accept, 2 ram accept
        logic [31:0] addr;
        logic [31:0] data;
    } ev_t;

    logic        clk_sys = 1'b0;
    logic        rst = 1'b1;
    logic        sdram_ready = 1'b0, reboot_req = 1'b0;
    logic [31:0] rom_address, ram_address, ram_writedata, rstctl_writedata;
    logic        rom_read, ram_write, rstctl_write, done;
    logic [1:0]  rstctl_address;
    logic        rom_waitrequest, ram_waitrequest;
    logic [31:0] rom_readdata = 32'h0;
    logic        rom_readdatavalid = 1'b0;

    // WORDS=0 instance
    logic        sdram_ready_z = 1'b0;
    logic [31:0] rom_address_z, ram_address_z, ram_writedata_z, rstctl_writedata_z;
    logic        rom_read_z, ram_write_z, rstctl_write_z, done_z;
    logic [1:0]  rstctl_address_z;

    int vectors = 0, miscompares = 0;
    ev_t exp_q[$];
    int rom_ws = 0, ram_ws = 0, rdv_delay = 1;
    int rom_cnt = 0, ram_cnt = 0, pend = 0;
    logic [31:0] rom_mem [4];

    always #5 clk_sys = ~clk_sys;

    ao486_boot_sequencer #(.SRC_BASE(SRC), .DST_BASE(DST), .WORDS(4)) dut (
        .clk_sys(clk_sys), .rst(rst), .sdram_ready(sdram_ready), .reboot_req(reboot_req),
        .rom_address(rom_address), .rom_read(rom_read), .rom_waitrequest(rom_waitrequest),
        .rom_readdata(rom_readdata), .rom_readdatavalid(rom_readdatavalid),
        .ram_address(ram_address), .ram_write(ram_write), .ram_writedata(ram_writedata),
        .ram_waitrequest(ram_waitrequest), .rstctl_address(rstctl_address),
        .rstctl_write(rstctl_write), .rstctl_writedata(rstctl_writedata), .done(done)
    );

    ao486_boot_sequencer #(.SRC_BASE(SRC), .DST_BASE(DST), .WORDS(0)) dut0 (
        .clk_sys(clk_sys), .rst(rst), .sdram_ready(sdram_ready_z), .reboot_req(1'b0),
        .rom_address(rom_address_z), .rom_read(rom_read_z), .rom_waitrequest(1'b0),
        .rom_readdata(32'h0), .rom_readdatavalid(1'b0),
        .ram_address(ram_address_z), .ram_write(ram_write_z), .ram_writedata(ram_writedata_z),
        .ram_waitrequest(1'b0), .rstctl_address(rstctl_address_z),
        .rstctl_write(rstctl_write_z), .rstctl_writedata(rstctl_writedata_z), .done(done_z)
    );

    // Memory slaves: programmable stall length and read-data latency.
    assign rom_waitrequest = rom_read && (rom_cnt < rom_ws);
    assign ram_waitrequest = ram_write && (ram_cnt < ram_ws);

    always @(posedge clk_sys) begin
        rom_readdatavalid <= 1'b0;
        if (rom_read && !rom_waitrequest) begin
            rom_cnt           <= 0;
            rom_readdata      <= rom_mem[rom_address[3:2]];
            rom_readdatavalid <= (rdv_delay == 1);
            pend              <= rdv_delay - 1;
        end else begin
            if (rom_read) rom_cnt <= rom_cnt + 1;
            if (pend != 0) begin
                pend              <= pend - 1;
                rom_readdatavalid <= (pend == 1);
            end
        end
        if (ram_write && !ram_waitrequest) ram_cnt <= 0;
        else if (ram_write) ram_cnt <= ram_cnt + 1;
    end

    // Monitor: bus events against the scoreboard, plus per-cycle invariants.
    ev_t got, want;
    logic hit;
    logic prev_rom_stall = 1'b0, prev_ram_stall = 1'b0;
    logic [31:0] prev_rom_addr = 32'h0, prev_ram_addr = 32'h0, prev_ram_data = 32'h0;

    always @(negedge clk_sys) begin
        if (rst) begin
            prev_rom_stall = 1'b0;
            prev_ram_stall = 1'b0;
        end else begin
            hit = 1'b1;
            if (rstctl_write) got = ev_t'{2'd0, {30'd0, rstctl_address}, rstctl_writedata};
            else if (rom_read && !rom_waitrequest) got = ev_t'{2'd1, rom_address, 32'd0};
            else if (ram_write && !ram_waitrequest) got = ev_t'{2'd2, ram_address, ram_writedata};
            else hit = 1'b0;
            if (hit) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_event: got %h expected none", got);
                end else begin
                    want = exp_q.pop_front();
                    if (got !== want) begin
                        miscompares++;
                        $display("FAIL bus_event: got %h expected %h", got, want);
                    end
                end
            end
            vectors++;
            if (rom_read && ram_write) begin
                miscompares++;
                $display("FAIL rd_wr_overlap: got 1 expected 0");
            end
            if (prev_rom_stall) begin
                vectors++;
                if ({rom_read, rom_address} !== {1'b1, prev_rom_addr}) begin
                    miscompares++;
                    $display("FAIL rom_stall_stable: got %b/%h expected 1/%h", rom_read, rom_address, prev_rom_addr);
                end
            end
            if (prev_ram_stall) begin
                vectors++;
                if ({ram_write, ram_address, ram_writedata} !== {1'b1, prev_ram_addr, prev_ram_data}) begin
                    miscompares++;
                    $display("FAIL ram_stall_stable: got %b/%h/%h expected 1/%h/%h",
                             ram_write, ram_address, ram_writedata, prev_ram_addr, prev_ram_data);
                end
            end
            vectors++;
            if (rom_read_z || ram_write_z) begin
                miscompares++;
                $display("FAIL zero_words_strobe: got %b%b expected 00", rom_read_z, ram_write_z);
            end
            prev_rom_stall = rom_read && rom_waitrequest;
            prev_rom_addr  = rom_address;
            prev_ram_stall = ram_write && ram_waitrequest;
            prev_ram_addr  = ram_address;
            prev_ram_data  = ram_writedata;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_seq();
        exp_q.push_back(ev_t'{2'd0, 32'd0, 32'd1});
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(ev_t'{2'd1, SRC + 32'(4 * i), 32'd0});
            exp_q.push_back(ev_t'{2'd2, DST + 32'(4 * i), rom_mem[i]});
        end
        exp_q.push_back(ev_t'{2'd0, 32'd0, 32'd0});
    endtask

    task automatic wait_done(input int limit);
        int n = 0;
        while (!done && n < limit) begin
            @(negedge clk_sys);
            n++;
        end
        check("done_reached", {31'd0, done}, 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rom_read"}, {31'd0, rom_read}, 32'd0);
        check({tag, "_ram_write"}, {31'd0, ram_write}, 32'd0);
        check({tag, "_rstctl_write"}, {31'd0, rstctl_write}, 32'd0);
        check({tag, "_rstctl_data"}, rstctl_writedata, 32'd0);
        check({tag, "_rstctl_addr"}, {30'd0, rstctl_address}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_ram_wdata"}, ram_writedata, 32'd0);
        check({tag, "_rom_addr"}, rom_address, SRC);
        check({tag, "_ram_addr"}, ram_address, DST);
    endtask

    task automatic pulse_reboot();
        reboot_req = 1'b1;
        @(negedge clk_sys);
        reboot_req = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rom_mem[0] = 32'hA0A0_0000; rom_mem[1] = 32'hA1A1_1111;
        rom_mem[2] = 32'hA2A2_2222; rom_mem[3] = 32'hA3A3_3333;
        repeat (3) @(posedge clk_sys);
        @(negedge clk_sys);
        check_reset_outputs("reset");
        rst = 1'b0;

        // Idle while SDRAM not ready; any strobe shows up as an unexpected event.
        repeat (100) @(negedge clk_sys);
        check("not_ready_done", {31'd0, done}, 32'd0);
        check("not_ready_rom_read", {31'd0, rom_read}, 32'd0);

        // Basic copy, zero-wait memories.
        push_seq();
        sdram_ready = 1'b1;
        @(negedge clk_sys);
        check("hold_next_cycle", {31'd0, rstctl_write}, 32'd1);
        wait_done(200);
        check("basic_queue_empty", 32'(exp_q.size()), 32'd0);

        // WORDS=0: HOLD then RELEASE back to back, then done.
        sdram_ready_z = 1'b1;
        @(negedge clk_sys);
        check("z_hold_write", {31'd0, rstctl_write_z}, 32'd1);
        check("z_hold_data", rstctl_writedata_z, 32'd1);
        @(negedge clk_sys);
        check("z_release_write", {31'd0, rstctl_write_z}, 32'd1);
        check("z_release_data", rstctl_writedata_z, 32'd0);
        @(negedge clk_sys);
        check("z_done", {31'd0, done_z}, 32'd1);
        check("z_rstctl_idle", {31'd0, rstctl_write_z}, 32'd0);

        // Stalled memories, re-copy triggered from DONE.
        rom_ws = 3; ram_ws = 5;
        rom_mem[0] = 32'hB0B0_0000; rom_mem[1] = 32'hB1B1_1111;
        rom_mem[2] = 32'hB2B2_2222; rom_mem[3] = 32'hB3B3_3333;
        push_seq();
        pulse_reboot();
        check("reboot_done_clr", {31'd0, done}, 32'd0);
        check("reboot_hold", {31'd0, rstctl_write}, 32'd1);
        wait_done(1000);
        check("stall_queue_empty", 32'(exp_q.size()), 32'd0);

        // reboot_req during WR is ignored.
        rom_ws = 0; ram_ws = 5;
        push_seq();
        pulse_reboot();
        begin
            int n = 0;
            while (!ram_write && n < 100) begin @(negedge clk_sys); n++; end
        end
        check("wr_reached", {31'd0, ram_write}, 32'd1);
        pulse_reboot();
        wait_done(1000);
        check("wr_reboot_ignored", 32'(exp_q.size()), 32'd0);
        repeat (3) @(negedge clk_sys);
        check("still_done", {31'd0, done}, 32'd1);

        // Reset during RD_WAIT with readdatavalid landing in IDLE.
        ram_ws = 0; rdv_delay = 3; sdram_ready = 1'b0;
        push_seq();
        pulse_reboot();
        begin
            int n = 0;
            while (!(rom_read && !rom_waitrequest && rom_address == SRC + 32'd4) && n < 100) begin
                @(negedge clk_sys); n++;
            end
            check("second_read_seen", rom_address, SRC + 32'd4);
        end
        @(negedge clk_sys);
        exp_q.delete();
        rst = 1'b1;
        @(negedge clk_sys);
        check_reset_outputs("midcopy");
        rst = 1'b0;
        repeat (4) @(negedge clk_sys);
        check("late_rdv_ignored", ram_writedata, 32'd0);
        check("late_rdv_no_write", {31'd0, ram_write}, 32'd0);
        rdv_delay = 1;
        push_seq();
        sdram_ready = 1'b1;
        wait_done(300);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ao486_boot_sequencer.md
AO486_BOOT_SEQUENCER -- requirements
Module: ao486_boot_sequencer

Interface
REQ-001 SHALL have parameter SRC_BASE, default 32'h00000000: byte base address of the BIOS image in boot ROM.
REQ-002 SHALL have parameter DST_BASE, default 32'h000F0000: byte base address of the BIOS copy in SDRAM.
REQ-003 SHALL have parameter WORDS, default 16384: number of 32-bit words to copy; legal range 0..65535.
REQ-004 SHALL have port clk_sys, input, 1 bit: system clock.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous, active-high, on clock clk_sys.
REQ-006 SHALL have port sdram_ready, input, 1 bit: SDRAM initialised.
REQ-007 SHALL have port reboot_req, input, 1 bit: request a re-copy and CPU restart.
REQ-008 SHALL have port rom_address, output, 32 bits: ROM read master byte address.
REQ-009 SHALL have port rom_read, output, 1 bit: ROM read strobe.
REQ-010 SHALL have port rom_waitrequest, input, 1 bit: ROM stall.
REQ-011 SHALL have port rom_readdata, input, 32 bits: ROM read data.
REQ-012 SHALL have port rom_readdatavalid, input, 1 bit: ROM read data valid.
REQ-013 SHALL have port ram_address, output, 32 bits: SDRAM write master byte address.
REQ-014 SHALL have port ram_write, output, 1 bit: SDRAM write strobe.
REQ-015 SHALL have port ram_writedata, output, 32 bits: SDRAM write data.
REQ-016 SHALL have port ram_waitrequest, input, 1 bit: SDRAM stall.
REQ-017 SHALL have ports rstctl_address, rstctl_write and rstctl_writedata, outputs, 2, 1 and 32 bits: CPU-reset register write port.
REQ-018 SHALL have port done, output, 1 bit: boot complete and CPU released.

Function
REQ-019 SHALL implement the states IDLE, HOLD, RD_REQ, RD_WAIT, WR, RELEASE and DONE.
REQ-020 IDLE: SHALL move to HOLD on the first clock with sdram_ready=1; sdram_ready SHALL be ignored in all other states.
REQ-021 HOLD: SHALL assert rstctl_write=1, rstctl_address=0 and rstctl_writedata=32'h1 for exactly one cycle.
REQ-022 HOLD exit: SHALL go to RD_REQ if WORDS>0, otherwise to RELEASE.
REQ-023 RD_REQ: SHALL hold rom_read=1 with a stable rom_address until a clock with rom_waitrequest=0, which ends the read request.
REQ-024 Read accept: if rom_readdatavalid=1 in the accept cycle, SHALL capture rom_readdata and go to WR; otherwise SHALL go to RD_WAIT.
REQ-025 RD_WAIT: SHALL capture rom_readdata on rom_readdatavalid=1 and go to WR; at most one read SHALL be outstanding.
REQ-026 WR: SHALL hold ram_write=1 with stable ram_address and ram_writedata (the captured word) until a clock with rom-independent ram_waitrequest=0.
REQ-027 Write accept: SHALL add 4 to rom_address and ram_address (mod 2^32) and increment a 16-bit word counter.
REQ-028 Write accept exit: SHALL go to RELEASE if the counter equals WORDS-1 before the increment, else to RD_REQ.
REQ-029 RELEASE: SHALL assert rstctl_write=1, rstctl_address=0 and rstctl_writedata=32'h0 for exactly one cycle, then go to DONE.
REQ-030 DONE: SHALL hold done=1.
REQ-031 DONE with reboot_req=1: SHALL clear done, restore rom_address=SRC_BASE, ram_address=DST_BASE and counter=0, and go to HOLD on the next clock.
REQ-032 reboot_req SHALL be ignored outside DONE.
REQ-033 rstctl_write SHALL never be asserted outside HOLD and RELEASE.
REQ-034 rom_read and ram_write SHALL never be asserted in the same cycle.
REQ-035 rom_read SHALL not assert before the HOLD write has been issued.

Reset
REQ-036 On rst=1 at a clock edge, the block SHALL set state=IDLE, rom_read=0, ram_write=0, rstctl_write=0, rstctl_address=0, rstctl_writedata=0, done=0, ram_writedata=0, rom_address=SRC_BASE, ram_address=DST_BASE and counter=0.
REQ-037 Reset mid-copy SHALL drop any strobe at that edge and abandon the outstanding read; a subsequent rom_readdatavalid SHALL be ignored while not in RD_REQ/RD_WAIT.
REQ-038 After reset, the block SHALL restart the full sequence from IDLE.

Verification
REQ-039 Basic copy: WORDS=4, zero-wait memories, readdatavalid one cycle after accept, ROM words A0..A3 -> exactly one HOLD write (data 1), SDRAM writes A0..A3 at F0000, F0004, F0008, F000C in order, then one RELEASE write (data 0), then done=1.
REQ-040 Stalls: rom_waitrequest high 3 cycles and ram_waitrequest high 5 cycles per access -> addresses and data stable throughout each stall, no duplicated or dropped words, same final SDRAM contents.
REQ-041 WORDS=0 -> HOLD write, RELEASE write on the next cycle, done=1; rom_read and ram_write never asserted.
REQ-042 sdram_ready held 0 for 100 cycles -> no strobes and done=0; sdram_ready=1 -> HOLD write on the following cycle.
REQ-043 reboot_req pulsed during WR and again in DONE -> first pulse has no effect; second pulse causes done=0, a HOLD write and a full re-copy starting at SRC_BASE/DST_BASE.
REQ-044 rst asserted during RD_WAIT, with late readdatavalid arriving in the IDLE cycle -> all outputs at reset values, data ignored, clean full sequence after sdram_ready.
